// File: rtl/instruction_fetch_data_if.sv
// Bundle of fetch-tag, issue, writeback and instruction-memory signals around the
// second fetch stage; the slave modport is the stage itself.
interface instruction_fetch_data_if #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 20
);
    logic                     ift_valid;
    logic [31:0]              ift_fetched_pc;
    logic [WAYS*TAG_BITS-1:0] ift_tags_read;
    logic [WAYS-1:0]          ift_valid_bits;
    logic                     ix_stall_if;
    logic                     wb_do_branch;
    logic                     ifd_cache_miss;
    logic                     ifd_resume_fetch;
    logic [WAYS-1:0]          ifd_update_tag_en;
    logic [SET_BITS-1:0]      ifd_update_tag_set;
    logic [TAG_BITS-1:0]      ifd_update_tag;
    logic                     mem_rd_req;
    logic [31:0]              mem_rd_addr;
    logic                     mem_rd_ack;
    logic                     mem_rd_valid;
    logic [31:0]              mem_rd_data;
    logic                     ifd_id_valid;
    logic [31:0]              ifd_id_pc;
    logic [31:0]              ifd_id_instr;

    modport slave (
        input  ift_valid, ift_fetched_pc, ift_tags_read, ift_valid_bits,
        input  ix_stall_if, wb_do_branch, mem_rd_ack, mem_rd_valid, mem_rd_data,
        output ifd_cache_miss, ifd_resume_fetch, ifd_update_tag_en, ifd_update_tag_set,
        output ifd_update_tag, mem_rd_req, mem_rd_addr, ifd_id_valid, ifd_id_pc, ifd_id_instr
    );

    modport master (
        output ift_valid, ift_fetched_pc, ift_tags_read, ift_valid_bits,
        output ix_stall_if, wb_do_branch, mem_rd_ack, mem_rd_valid, mem_rd_data,
        input  ifd_cache_miss, ifd_resume_fetch, ifd_update_tag_en, ifd_update_tag_set,
        input  ifd_update_tag, mem_rd_req, mem_rd_addr, ifd_id_valid, ifd_id_pc, ifd_id_instr
    );
endinterface

// File: rtl/instruction_fetch_data.sv
// Second fetch stage: hit detection against presented tags, I-cache data arrays,
// delivery to ID and line fill from instruction memory on a miss.
module instruction_fetch_data #(
    parameter int ICACHE_NUM_WAYS = 4,
    parameter int ICACHE_NUM_SETS = 64,
    parameter int CL_SIZE_BYTES   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_data_if.slave   bus
);
    localparam int WAYS      = ICACHE_NUM_WAYS;
    localparam int OFS_BITS  = $clog2(CL_SIZE_BYTES);
    localparam int SET_BITS  = $clog2(ICACHE_NUM_SETS);
    localparam int TAG_BITS  = 32 - SET_BITS - OFS_BITS;
    localparam int WORDS     = CL_SIZE_BYTES / 4;
    localparam int WORD_BITS = OFS_BITS - 2;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int DEPTH     = ICACHE_NUM_SETS * WORDS;

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_FILL = 2'd2,
        MISS_DONE = 2'd3
    } state_t;

    function automatic logic [WAYS-1:0] onehot(input logic [WAY_BITS-1:0] idx);
        logic [WAYS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                state_r;
    logic [WORD_BITS-1:0]  beat_r;
    logic [WAY_BITS-1:0]   rr_r;
    logic [WAY_BITS-1:0]   victim_r;
    logic                  victim_rr_r;
    logic [TAG_BITS-1:0]   tag_r;
    logic [SET_BITS-1:0]   set_r;
    logic [WAY_BITS-1:0]   hit_way_r;
    logic                  id_valid_r;
    logic [31:0]           id_pc_r;
    logic [31:0]           rd_data_r [WAYS];
    logic [31:0]           ram_r [WAYS][DEPTH];

    logic [TAG_BITS-1:0]   pc_tag_s;
    logic [SET_BITS-1:0]   pc_set_s;
    logic [WORD_BITS-1:0]  pc_word_s;
    logic                  hit_s;
    logic [WAY_BITS-1:0]   hit_way_s;
    logic                  inv_found_s;
    logic [WAY_BITS-1:0]   inv_way_s;
    logic                  lookup_s;
    logic                  fetch_s;
    logic                  miss_s;
    logic                  fill_beat_s;
    logic                  last_beat_s;
    logic                  unused_s;

    assign pc_tag_s  = bus.ift_fetched_pc[31 -: TAG_BITS];
    assign pc_set_s  = bus.ift_fetched_pc[OFS_BITS +: SET_BITS];
    assign pc_word_s = bus.ift_fetched_pc[2 +: WORD_BITS];
    assign unused_s  = ^bus.ift_fetched_pc[1:0];

    // Tag compare and invalid-way search; descending scan leaves the lowest index.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.ift_valid_bits[w] && (bus.ift_tags_read[w*TAG_BITS +: TAG_BITS] == pc_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_BITS'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!bus.ift_valid_bits[w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_BITS'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
    end

    assign lookup_s    = rst && (state_r == LOOKUP) && !bus.ix_stall_if;
    assign fetch_s     = lookup_s && bus.ift_valid && !bus.wb_do_branch;
    assign miss_s      = fetch_s && !hit_s;
    assign fill_beat_s = rst && (state_r == MISS_FILL) && bus.mem_rd_valid;
    assign last_beat_s = fill_beat_s && (beat_r == WORD_BITS'(WORDS - 1));

    assign bus.ifd_cache_miss     = miss_s;
    assign bus.ifd_resume_fetch   = rst && (state_r == MISS_DONE);
    assign bus.ifd_update_tag_en  = last_beat_s ? onehot(victim_r) : '0;
    assign bus.ifd_update_tag_set = set_r;
    assign bus.ifd_update_tag     = tag_r;
    assign bus.mem_rd_req         = rst && (state_r == MISS_REQ);
    assign bus.mem_rd_addr        = {tag_r, set_r, {OFS_BITS{1'b0}}};
    assign bus.ifd_id_valid       = id_valid_r;
    assign bus.ifd_id_pc          = id_pc_r;
    assign bus.ifd_id_instr       = rd_data_r[hit_way_r];

    // Data array fill port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_beat_s) begin
            ram_r[victim_r][{set_r, beat_r}] <= bus.mem_rd_data;
        end
    end

    // Data array read port; output register holds while stalled or filling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) rd_data_r[w] <= 32'h0;
        end else if (lookup_s) begin
            for (int w = 0; w < WAYS; w++) rd_data_r[w] <= ram_r[w][{pc_set_s, pc_word_s}];
        end
    end

    // Fill sequencer and ID output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= LOOKUP;
            beat_r      <= '0;
            rr_r        <= '0;
            victim_r    <= '0;
            victim_rr_r <= 1'b0;
            tag_r       <= '0;
            set_r       <= '0;
            hit_way_r   <= '0;
            id_valid_r  <= 1'b0;
            id_pc_r     <= 32'h0;
        end else begin
            case (state_r)
                LOOKUP: begin
                    if (lookup_s) begin
                        id_valid_r <= fetch_s && hit_s;
                        id_pc_r    <= bus.ift_fetched_pc;
                        hit_way_r  <= hit_way_s;
                        if (miss_s) begin
                            tag_r       <= pc_tag_s;
                            set_r       <= pc_set_s;
                            victim_r    <= inv_found_s ? inv_way_s : rr_r;
                            victim_rr_r <= !inv_found_s;
                            state_r     <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    id_valid_r <= 1'b0;
                    if (bus.mem_rd_ack) begin
                        beat_r  <= '0;
                        state_r <= MISS_FILL;
                    end
                end
                MISS_FILL: begin
                    id_valid_r <= 1'b0;
                    if (bus.mem_rd_valid) begin
                        beat_r <= beat_r + WORD_BITS'(1);
                        if (last_beat_s) begin
                            state_r <= MISS_DONE;
                        end
                    end
                end
                MISS_DONE: begin
                    id_valid_r <= 1'b0;
                    if (victim_rr_r) begin
                        rr_r <= (rr_r == WAY_BITS'(WAYS - 1)) ? '0 : rr_r + WAY_BITS'(1);
                    end
                    state_r <= LOOKUP;
                end
                default: begin
                    id_valid_r <= 1'b0;
                    state_r    <= LOOKUP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_data.sv
// Self-checking bench for instruction_fetch_data: vector table with an ID-output
// scoreboard, plus sequences for fills, replacement, stall and reset mid-fill.
module tb_instruction_fetch_data;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_data_if #(.WAYS(4), .SET_BITS(6), .TAG_BITS(20)) bus ();

    instruction_fetch_data #(
        .ICACHE_NUM_WAYS(4), .ICACHE_NUM_SETS(64), .CL_SIZE_BYTES(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [79:0] tags;
        logic [3:0]  vb;
        logic        br;
        logic        exp_hit;
        int          exp_way;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t        vecs [7];
    exp_t        sb [$];
    logic [31:0] model [4][64][16];

    function automatic logic [31:0] fw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("id_valid", bus.ifd_id_valid, e.v);
            if (e.v) begin
                chk("id_pc", bus.ifd_id_pc, e.pc);
                chk("id_instr", bus.ifd_id_instr, e.instr);
            end
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.mem_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_rd_req_seen", bus.mem_rd_req, 1'b1);
    endtask

    // Called at the negedge just after the miss was registered.
    task automatic do_fill(input logic [31:0] base, input int way, input int set,
                           input logic [19:0] tag, input logic br);
        bus.wb_do_branch = br;
        wait_req();
        chk("mem_rd_addr", bus.mem_rd_addr, base);
        @(negedge clk);
        chk("mem_rd_req_hold", bus.mem_rd_req, 1'b1);
        chk("mem_rd_addr_hold", bus.mem_rd_addr, base);
        bus.mem_rd_ack = 1'b1;
        @(negedge clk);
        bus.mem_rd_ack = 1'b0;
        chk("mem_rd_req_drop", bus.mem_rd_req, 1'b0);
        for (int b = 0; b < 16; b++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = fw(base + 32'(4 * b));
            model[way][set][b] = bus.mem_rd_data;
            #1;
            chk("miss_in_fill", bus.ifd_cache_miss, 1'b0);
            if (b == 15) begin
                chk("upd_tag_en", bus.ifd_update_tag_en, 32'(4'b0001 << way));
                chk("upd_tag_set", bus.ifd_update_tag_set, 32'(set));
                chk("upd_tag", bus.ifd_update_tag, tag);
                chk("resume_early", bus.ifd_resume_fetch, 1'b0);
            end else begin
                chk("upd_tag_en_mid", bus.ifd_update_tag_en, 4'b0000);
            end
            @(negedge clk);
            if (b == 7) begin
                bus.mem_rd_valid = 1'b0;
                #1;
                chk("upd_tag_en_gap", bus.ifd_update_tag_en, 4'b0000);
                @(negedge clk);
            end
        end
        bus.mem_rd_valid = 1'b0;
        chk("resume", bus.ifd_resume_fetch, 1'b1);
        chk("upd_tag_en_done", bus.ifd_update_tag_en, 4'b0000);
        chk("miss_in_done", bus.ifd_cache_miss, 1'b0);
        bus.ift_valid    = 1'b0;
        bus.wb_do_branch = 1'b0;
        @(negedge clk);
        chk("resume_one_cycle", bus.ifd_resume_fetch, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] pc;

        bus.ift_valid = 1'b1; bus.ift_fetched_pc = 32'h0000_1004; bus.ift_tags_read = '0;
        bus.ift_valid_bits = 4'b0000; bus.ix_stall_if = 1'b0; bus.wb_do_branch = 1'b0;
        bus.mem_rd_ack = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = 32'h0;

        // Reset state, with a would-be miss presented during reset.
        repeat (2) @(negedge clk);
        chk("rst_id_valid", bus.ifd_id_valid, 1'b0);
        chk("rst_id_pc", bus.ifd_id_pc, 32'h0);
        chk("rst_id_instr", bus.ifd_id_instr, 32'h0);
        chk("rst_req", bus.mem_rd_req, 1'b0);
        chk("rst_addr", bus.mem_rd_addr, 32'h0);
        chk("rst_tag_en", bus.ifd_update_tag_en, 4'b0000);
        chk("rst_tag_set", bus.ifd_update_tag_set, 6'h00);
        chk("rst_tag", bus.ifd_update_tag, 20'h00000);
        chk("rst_miss", bus.ifd_cache_miss, 1'b0);
        chk("rst_resume", bus.ifd_resume_fetch, 1'b0);
        rst = 1'b1;

        // Cold miss into set 0, way 0.
        #1;
        chk("cold_miss", bus.ifd_cache_miss, 1'b1);
        @(negedge clk);
        do_fill(32'h0000_1000, 0, 0, 20'h00001, 1'b0);

        vecs[0] = '{1'b1, 32'h0000_1004, {60'h0, 20'h1}, 4'b0001, 1'b0, 1'b1, 0};
        vecs[1] = '{1'b1, 32'h0000_1008, {60'h0, 20'h1}, 4'b0001, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b1, 32'h0000_103C, {60'h0, 20'h1}, 4'b0001, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 32'h0000_1000, {60'h0, 20'h1}, 4'b0001, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 32'h0000_2000, {60'h0, 20'h1}, 4'b0001, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b0, 32'h0000_1010, {60'h0, 20'h1}, 4'b0001, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 32'h0000_1020, {20'h0, 20'h1, 20'h0, 20'h1}, 4'b0101, 1'b0, 1'b1, 0};

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) check_out();
            bus.ift_valid      = vecs[i].vld;
            bus.ift_fetched_pc = vecs[i].pc;
            bus.ift_tags_read  = vecs[i].tags;
            bus.ift_valid_bits = vecs[i].vb;
            bus.wb_do_branch   = vecs[i].br;
            #1;
            chk("vec_miss", bus.ifd_cache_miss, 1'b0);
            e.v     = vecs[i].exp_hit;
            e.pc    = vecs[i].pc;
            e.instr = vecs[i].exp_hit ? model[vecs[i].exp_way][vecs[i].pc[11:6]][vecs[i].pc[5:2]] : 32'h0;
            sb.push_back(e);
        end
        @(negedge clk);
        check_out();
        bus.ift_valid = 1'b0; bus.wb_do_branch = 1'b0;

        // Stall after a hit: outputs hold, non-matching lookup raises no miss.
        @(negedge clk);
        bus.ift_valid = 1'b1; bus.ift_fetched_pc = 32'h0000_1008;
        bus.ift_tags_read = {60'h0, 20'h1}; bus.ift_valid_bits = 4'b0001;
        @(negedge clk);
        chk("stall_pre_valid", bus.ifd_id_valid, 1'b1);
        chk("stall_pre_pc", bus.ifd_id_pc, 32'h0000_1008);
        bus.ix_stall_if = 1'b1;
        bus.ift_fetched_pc = 32'h0000_5000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_miss", bus.ifd_cache_miss, 1'b0);
            @(negedge clk);
            chk("stall_valid", bus.ifd_id_valid, 1'b1);
            chk("stall_pc", bus.ifd_id_pc, 32'h0000_1008);
            chk("stall_instr", bus.ifd_id_instr, model[0][0][2]);
        end
        bus.ix_stall_if = 1'b0; bus.ift_valid = 1'b0;
        @(negedge clk);
        chk("unstall_valid", bus.ifd_id_valid, 1'b0);

        // Replacement in a full set 3: round-robin victims 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pc = ((32'h20 + 32'(k)) << 12) | 32'h0000_00C0;
            bus.ift_valid = 1'b1; bus.ift_fetched_pc = pc;
            bus.ift_tags_read = {20'h13, 20'h12, 20'h11, 20'h10}; bus.ift_valid_bits = 4'b1111;
            #1;
            chk("repl_miss", bus.ifd_cache_miss, 1'b1);
            @(negedge clk);
            do_fill(pc & 32'hFFFF_FFC0, k % 4, 3, 20'(32'h20 + 32'(k)), k == 1);
        end

        // Hit on the last replaced line in way 0 of set 3.
        @(negedge clk);
        bus.ift_valid = 1'b1; bus.ift_fetched_pc = 32'h0002_40C4;
        bus.ift_tags_read = {60'h0, 20'h24}; bus.ift_valid_bits = 4'b0001;
        @(negedge clk);
        bus.ift_valid = 1'b0;
        chk("repl_hit_valid", bus.ifd_id_valid, 1'b1);
        chk("repl_hit_instr", bus.ifd_id_instr, fw(32'h0002_40C4));

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.ift_valid = 1'b1; bus.ift_fetched_pc = 32'h0000_7000; bus.ift_valid_bits = 4'b0000;
        #1;
        chk("mid_miss", bus.ifd_cache_miss, 1'b1);
        @(negedge clk);
        bus.ift_valid = 1'b0;
        wait_req();
        bus.mem_rd_ack = 1'b1;
        @(negedge clk);
        bus.mem_rd_ack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.mem_rd_valid = 1'b1; bus.mem_rd_data = fw(32'h7000 + 32'(4 * b));
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", bus.mem_rd_req, 1'b0);
        chk("mid_rst_addr", bus.mem_rd_addr, 32'h0);
        chk("mid_rst_id_valid", bus.ifd_id_valid, 1'b0);
        rst = 1'b1;
        for (int b = 5; b < 16; b++) begin
            bus.mem_rd_data = fw(32'h7000 + 32'(4 * b));
            #1;
            chk("stray_tag_en", bus.ifd_update_tag_en, 4'b0000);
            chk("stray_resume", bus.ifd_resume_fetch, 1'b0);
            @(negedge clk);
        end
        bus.mem_rd_valid = 1'b0;
        chk("stray_resume_end", bus.ifd_resume_fetch, 1'b0);
        chk("stray_req_end", bus.mem_rd_req, 1'b0);
        bus.ift_valid = 1'b1;
        #1;
        chk("post_rst_lookup", bus.ifd_cache_miss, 1'b1);
        bus.ift_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_data.md
Name: instruction_fetch_data

Overview:
Second instruction-fetch stage. It consumes the PC, per-way tags and per-way valid bits presented by the fetch-tag stage, and performs hit detection. It owns the I-cache data arrays: on a hit it delivers the instruction to ID, and on a miss it runs a line fill from instruction memory. When the fill completes it writes the new tag back to the fetch-tag stage and releases fetch with resume_fetch.

Parameters:
ICACHE_NUM_WAYS, 4, associativity
ICACHE_NUM_SETS, 64, sets per way (power of 2)
CL_SIZE_BYTES, 64, line size in bytes (power of 2, >=8)
Derived: OFS_BITS=log2(CL_SIZE_BYTES); SET_BITS=log2(ICACHE_NUM_SETS); TAG_BITS=32-SET_BITS-OFS_BITS; WORDS=CL_SIZE_BYTES/4

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
ift_valid  in  1  fetch-tag stage presents a fetch this cycle
ift_fetched_pc  in  32  fetched PC, word aligned
ift_tags_read  in  WAYS*TAG_BITS  tag of each way for the PC's set, way 0 in LSBs
ift_valid_bits  in  WAYS  line-valid bit of each way
ix_stall_if  in  1  backpressure from issue; holds ID outputs
wb_do_branch  in  1  redirect; current fetch is wrong-path
ifd_cache_miss  out  1  miss pulse to fetch-tag stage (combinational)
ifd_resume_fetch  out  1  fill-done pulse to fetch-tag stage
ifd_update_tag_en  out  WAYS  one-hot tag/valid write
ifd_update_tag_set  out  SET_BITS  set to update
ifd_update_tag  out  TAG_BITS  tag to write
mem_rd_req  out  1  line-fill request
mem_rd_addr  out  32  line-aligned fill address
mem_rd_ack  in  1  request accepted
mem_rd_valid  in  1  fill data beat valid
mem_rd_data  in  32  fill data word, ascending address order
ifd_id_valid  out  1  instruction valid to ID
ifd_id_pc  out  32  PC of instruction
ifd_id_instr  out  32  instruction word

Behaviour:
- Address split: tag=pc[31:SET_BITS+OFS_BITS], set=pc[SET_BITS+OFS_BITS-1:OFS_BITS], word=pc[OFS_BITS-1:2].
- Data array: WAYS x SETS x WORDS x 32b synchronous-read RAM.
  - All ways are read at {set,word} of ift_fetched_pc every cycle the state is LOOKUP and ix_stall_if=0.
  - Fill writes go to the victim way only.
- hit_vec[w] = ift_valid_bits[w] && tag match. Any bit set means hit. The lowest-index matching way wins when several match.
- FSM states: LOOKUP, MISS_REQ, MISS_FILL, MISS_DONE. Reset state is LOOKUP.
- LOOKUP:
  - Hit: when ift_valid=1, wb_do_branch=0 and hit. Registered so that in cycle N+1: ifd_id_valid=1, ifd_id_pc=PC, ifd_id_instr=selected way's word.
  - Miss: when ift_valid=1, wb_do_branch=0 and no hit.
    - ifd_cache_miss=1 combinationally in cycle N.
    - Latch line address {tag,set,0}.
    - Victim = lowest invalid way; if no way is invalid, victim = round-robin counter.
    - Next state MISS_REQ; ifd_id_valid=0 in cycle N+1.
  - Otherwise ifd_id_valid=0 next cycle.
- MISS_REQ: mem_rd_req=1 and mem_rd_addr held stable until mem_rd_ack=1. Then clear beat counter and go to MISS_FILL.
- MISS_FILL:
  - Each mem_rd_valid beat writes mem_rd_data to victim[set][beat]; beat counter increments.
  - On beat WORDS-1, in that same cycle: ifd_update_tag_en=onehot(victim), ifd_update_tag_set=set, ifd_update_tag=tag. Go to MISS_DONE.
- MISS_DONE: ifd_resume_fetch=1 for exactly one cycle. The round-robin counter advances (mod WAYS) only if the victim came from the counter. Return to LOOKUP.
- Outside LOOKUP: ift_valid ignored; ifd_cache_miss=0; ifd_id_valid=0.
- ix_stall_if=1: ifd_id_valid/pc/instr registers and the data-RAM output hold their values. Lookup results of that cycle are discarded; no miss is raised.
- wb_do_branch=1 in LOOKUP: no miss is raised and ifd_id_valid=0 next cycle, even on a hit.
- wb_do_branch during a fill: the fill always completes, including the tag write and the resume_fetch pulse; the fill is not cancelled.
- ifd_update_tag_en, ifd_cache_miss and ifd_resume_fetch are never asserted in the same cycle.
- Reset (also mid-fill): state=LOOKUP, beat counter=0, round-robin counter=0. All outputs 0: ifd_id_valid, ifd_id_pc, ifd_id_instr, mem_rd_req, mem_rd_addr, update_tag_en/set/tag, miss, resume. Stray mem_rd_valid beats after reset are ignored. Data RAM contents are not reset.

Test Plan:
- Cold miss: ift_valid=1, pc=0x0000_1004, all valid_bits=0 -> ifd_cache_miss=1 same cycle. Then mem_rd_req with addr=0x0000_1000; after ack and 16 beats: update_tag_en=0001, set=0, tag=0x00001. Then resume_fetch one cycle.
- Hit after fill: re-present pc=0x0000_1004 with tags_read[way0]=0x00001 and valid_bits=0001 -> next cycle ifd_id_valid=1, pc=0x0000_1004, instr=beat 1 data.
- Replacement: all 4 ways valid, 5 consecutive misses to set 3 -> victims 0,1,2,3,0.
- Branch kill: hit presented with wb_do_branch=1 -> ifd_id_valid=0 next cycle; a miss under the same condition -> no ifd_cache_miss.
- Stall: ix_stall_if=1 for 3 cycles after a hit -> ifd_id_pc/instr held; no miss raised on a non-matching lookup.
- Reset mid-fill: rst=0 after 5 beats -> next cycle mem_rd_req=0, state LOOKUP. Remaining beats cause no tag update and no resume pulse.
